// File: rtl/swd_bridge_pkg.sv
// SWD bridge shared definitions.
// Frame geometry, bit-slot indices and line ownership rule.
package swd_bridge_pkg;

  localparam int FRAME_BITS = 48;

  typedef logic [5:0] bit_idx_t;

  localparam bit_idx_t BIT_LAST       = bit_idx_t'(FRAME_BITS - 1);
  localparam bit_idx_t BIT_REQ_LO     = 6'd2;
  localparam bit_idx_t BIT_TRN1       = 6'd10;
  localparam bit_idx_t BIT_ACK_LO     = 6'd11;
  localparam bit_idx_t BIT_DATA_RD_LO = 6'd14;
  localparam bit_idx_t BIT_PAR_RD     = 6'd46;
  localparam bit_idx_t BIT_TRN2_WR    = 6'd14;
  localparam bit_idx_t BIT_DATA_WR_LO = 6'd15;
  localparam bit_idx_t BIT_PAR_WR     = 6'd47;

  localparam logic [2:0] ACK_OK = 3'b001;

  // Host drives pad+REQ always, and WRITE data+parity after an OK ACK.
  function automatic logic host_owns(
    input bit_idx_t   c,
    input logic       rd,
    input logic [2:0] ack
  );
    logic hdr;
    logic wr;
    hdr = c < BIT_TRN1;
    wr  = !rd && (ack == ACK_OK)
        && (c > BIT_TRN2_WR)
        && (c >= BIT_DATA_WR_LO)
        && (c <= BIT_PAR_WR);
    return hdr || wr;
  endfunction

endpackage

// File: rtl/swd_bridge_top_seq.sv
// SWD frame sequencer.
// Bit counter, ACK capture, negedge line-ownership register.
module swd_frame_seq
  import swd_bridge_pkg::*;
(
  input  logic sck,
  input  logic rst_n,
  input  logic rnw,
  input  logic swdio_in,
  output logic oe
);

  bit_idx_t   bit_cnt_q, bit_cnt_d;
  logic [2:0] ack_q, ack_d;
  logic       oe_q, oe_d;

  // Next bit index and ACK bits sampled from the line.
  always_comb begin
    bit_cnt_d = bit_cnt_q + 6'd1;
    ack_d     = ack_q;
    if (!rst_n) begin
      bit_cnt_d = '0;
      ack_d     = '0;
    end else if (bit_cnt_q == BIT_LAST) begin
      bit_cnt_d = '0;
      ack_d     = '0;
    end else begin
      unique case (bit_cnt_q)
        BIT_ACK_LO:        ack_d[0] = swdio_in;
        BIT_ACK_LO + 6'd1: ack_d[1] = swdio_in;
        BIT_ACK_LO + 6'd2: ack_d[2] = swdio_in;
        default: ;
      endcase
    end
  end

  // Counter and ACK advance on the sampling edge.
  always_ff @(posedge sck) begin
    bit_cnt_q <= bit_cnt_d;
    ack_q     <= ack_d;
  end

  // Ownership for the bit about to be driven.
  always_comb begin
    oe_d = 1'b1;
    if (rst_n) begin
      oe_d = host_owns(bit_cnt_q, rnw, ack_q);
    end
  end

  // Ownership changes on the driving edge.
  always_ff @(negedge sck) begin
    oe_q <= oe_d;
  end

  assign oe = oe_q;

endmodule

// File: rtl/swd_spi_bridge_top.sv
// SPI-to-SWD bridge top.
// SWDIO tri-state mux, swclk forward, miso readback.
module swd_spi_bridge_top
  import swd_bridge_pkg::*;
(
  input  logic sck,
  input  logic rst_n,
  input  logic mosi,
  output logic miso,
  input  logic rnw,
  output logic swclk,
  inout  wire  swdio
);

  logic seq_oe;
  logic oe;

  swd_frame_seq u_seq (
    .sck      (sck),
    .rst_n    (rst_n),
    .rnw      (rnw),
    .swdio_in (swdio),
    .oe       (seq_oe)
  );

  assign oe    = !rst_n || seq_oe;
  assign swdio = oe ? mosi : 1'bz;
  assign miso  = swdio;
  assign swclk = sck;

endmodule

// File: tb/tb_swd_spi_bridge_top.sv
// Bench for the SPI-to-SWD bridge.
// Scoreboard of expected line levels per bit.
module tb_swd_spi_bridge_top;

  logic sck   = 1'b0;
  logic rst_n = 1'b0;
  logic mosi  = 1'b0;
  logic rnw   = 1'b0;
  logic miso;
  logic swclk;
  wire  swdio;

  logic tgt_oe = 1'b0;
  logic tgt_d  = 1'b0;

  assign swdio = tgt_oe ? tgt_d : 1'bz;

  swd_spi_bridge_top dut (
    .sck   (sck),
    .rst_n (rst_n),
    .mosi  (mosi),
    .miso  (miso),
    .rnw   (rnw),
    .swclk (swclk),
    .swdio (swdio)
  );

  always #5 sck = ~sck;

  typedef struct {
    logic lvl;
    int   fr;
    int   b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int fr, input int b,
                     input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s frame %0d bit %0d got %b want %b",
               nm, fr, b, act, exp);
    end
  endtask

  // Monitor: every bit sample point, compare against the oldest expectation.
  initial begin
    exp_t e;
    logic s;
    forever begin
      @(posedge sck);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        s = swdio;
        chk("swdio", e.fr, e.b, s, e.lvl);
        chk("miso", e.fr, e.b, miso, e.lvl);
        chk("swclk", e.fr, e.b, swclk, 1'b1);
      end
    end
  end

  // One bit: host value hv when host owns (or RAW), else target drives tv
  // while mosi carries the opposite level so any bridge contention shows.
  task automatic drive_bit(input int fr, input int b, input logic rst,
                           input logic rd, input logic host,
                           input logic hv, input logic tv);
    exp_t e;
    @(negedge sck);
    rst_n = rst;
    rnw   = rd;
    if (!rst || host) begin
      mosi   = hv;
      tgt_oe = 1'b0;
      tgt_d  = 1'b0;
      e.lvl  = hv;
    end else begin
      mosi   = ~tv;
      tgt_oe = 1'b1;
      tgt_d  = tv;
      e.lvl  = tv;
    end
    e.fr = fr;
    e.b  = b;
    exp_q.push_back(e);
  endtask

  task automatic raw_bits(input int fr, input logic [15:0] pat,
                          input int n);
    for (int i = 0; i < n; i++) begin
      drive_bit(fr, i, 1'b0, rnw, 1'b1, pat[4'(i)], 1'b0);
    end
  endtask

  // Reference: who owns each slot and what value it carries.
  task automatic run_frame(input int fr, input logic rd,
                           input logic [7:0] req, input logic [2:0] ack,
                           input logic [31:0] data, input int abort_at);
    logic ok;
    ok = (ack == 3'b001);
    for (int b = 0; b < 48; b++) begin
      logic host;
      logic hv;
      logic tv;
      if (b == abort_at) begin
        drive_bit(fr, b, 1'b0, rd, 1'b1,
                  1'($urandom_range(0, 1)), 1'b0);
        return;
      end
      host = (b < 10) || (!rd && ok && b >= 15);
      hv = 1'b0;
      if (b >= 2 && b < 10) hv = req[3'(b - 2)];
      else if (b >= 15 && b < 47) hv = data[5'(b - 15)];
      else if (b == 47) hv = ^data;
      tv = 1'($urandom_range(0, 1));
      if (b >= 11 && b <= 13) tv = ack[2'(b - 11)];
      else if (rd && ok && b >= 14 && b <= 45) tv = data[5'(b - 14)];
      else if (rd && ok && b == 46) tv = ^data;
      drive_bit(fr, b, 1'b1, rd, host, hv, tv);
    end
  endtask

  initial begin
    logic [2:0] a;
    raw_bits(0, 16'hA5C3, 16);
    run_frame(1, 1'b1, 8'hA5, 3'b001, 32'h12345678, -1);
    run_frame(2, 1'b1, 8'hA5, 3'b010, $urandom, -1);
    run_frame(3, 1'b0, 8'hA1, 3'b001, 32'hDEADBEEF, -1);
    run_frame(4, 1'b0, 8'hA1, 3'b100, $urandom, -1);
    raw_bits(5, 16'h0001, 1);
    run_frame(6, 1'b1, 8'hA5, 3'b001, $urandom, 20);
    raw_bits(7, 16'($urandom), 3);
    run_frame(8, 1'b0, 8'hB1, 3'b001, $urandom, -1);
    for (int f = 9; f < 17; f++) begin
      case ($urandom_range(0, 3))
        0:       a = 3'b001;
        1:       a = 3'b010;
        2:       a = 3'b100;
        default: a = 3'($urandom);
      endcase
      run_frame(f, 1'($urandom_range(0, 1)), 8'($urandom), a,
                $urandom, -1);
    end
    raw_bits(17, 16'($urandom), 4);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge sck);
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
